// File: rtl/voice_mixer.sv
// Per-frame voice mixer: on each codec LR-clock rising edge it snapshots the voices, sums the
// active ones serially, applies volume and headroom, and saturates. Optional: VOICE_MIXER_CLIP_HOLD_EN.
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_SHIFT = 3,
    parameter int CLIP_HOLD  = 4800
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           lrck,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [7:0]                     volume,
    output logic [SAMPLE_W-1:0]            LDATA,
    output logic [SAMPLE_W-1:0]            RDATA,
    output logic                           sample_strobe,
    output logic                           busy,
    output logic [7:0]                     overrun_cnt,
    output logic                           clip
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_W + IDX_W;
    localparam int PROD_W = ACC_W + 9;
    localparam int SHIFT  = 7 + GAIN_SHIFT;

    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

    state_t                     state;
    logic                       sync1, sync2, sync3;
    logic                       frame_edge;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic [SAMPLE_W-1:0]        samples_s [NUM_VOICES];
    logic [NUM_VOICES-1:0]      active_s;
    logic [7:0]                 vol_s;
    logic signed [SAMPLE_W-1:0] cur_sample;
    logic signed [ACC_W-1:0]    addend;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   shifted;
    logic                       over_hi, under_lo;
    logic [SAMPLE_W-1:0]        mixed;

    // lrck is asynchronous: two synchronizing flops plus a history flop for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= lrck;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign frame_edge = sync2 & ~sync3;

    always_comb begin
        cur_sample = samples_s[idx];
        addend     = active_s[idx] ? {{IDX_W{cur_sample[SAMPLE_W-1]}}, cur_sample} : '0;
        prod       = $signed({{9{acc[ACC_W-1]}}, acc}) * $signed({{(PROD_W-8){1'b0}}, vol_s});
        // Arithmetic shift floors toward negative infinity; no rounding is applied
        shifted    = prod >>> SHIFT;
        over_hi    = shifted > SAT_MAX;
        under_lo   = shifted < SAT_MIN;
        mixed      = shifted[SAMPLE_W-1:0];
        if (over_hi) begin
            mixed = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (under_lo) begin
            mixed = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end

    // The sample is loaded as the FSM leaves SCALE so LDATA and the strobe are visible during OUT
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            idx           <= '0;
            acc           <= '0;
            active_s      <= '0;
            vol_s         <= '0;
            LDATA         <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
            overrun_cnt   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                samples_s[i] <= '0;
            end
        end else begin
            sample_strobe <= 1'b0;
            if (frame_edge && state != IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (frame_edge) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            samples_s[i] <= voice_data[i*SAMPLE_W +: SAMPLE_W];
                        end
                        active_s <= voice_active;
                        vol_s    <= volume;
                        acc      <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_VOICES - 1)) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    LDATA         <= mixed;
                    sample_strobe <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign RDATA = LDATA;

`ifdef VOICE_MIXER_CLIP_HOLD_EN
    localparam int HOLD_W = $clog2(CLIP_HOLD + 1);

    logic              sat_hit;
    logic              sat_seen;
    logic [HOLD_W-1:0] hold_cnt;

    assign sat_hit = over_hi | under_lo;

    // Clip stays up for CLIP_HOLD clean frames after the most recent saturation
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sat_seen <= 1'b0;
            hold_cnt <= '0;
            clip     <= 1'b0;
        end else begin
            if (state == SCALE) begin
                sat_seen <= sat_hit;
            end
            if (state == OUT) begin
                if (sat_seen) begin
                    hold_cnt <= HOLD_W'(CLIP_HOLD);
                    clip     <= 1'b1;
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                    clip     <= (hold_cnt != HOLD_W'(1));
                end
            end
        end
    end
`else
    // Hold time is irrelevant without the clip feature; the compare is constant false
    assign clip = (CLIP_HOLD < 0);
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: each frame's expected sample is queued when lrck is
// raised and compared when the strobe fires; latency, overrun, snapshot and reset are also checked.
module tb_voice_mixer;

    localparam int NV = 8;
    localparam int SW = 16;

    logic            Clk;
    logic            Reset;
    logic            lrck;
    logic [NV*SW-1:0] voice_data;
    logic [NV-1:0]   voice_active;
    logic [7:0]      volume;
    logic [SW-1:0]   LDATA;
    logic [SW-1:0]   RDATA;
    logic            sample_strobe;
    logic            busy;
    logic [7:0]      overrun_cnt;
    logic            clip;

    int              compareCount = 0;
    int              failCount    = 0;
    logic [SW-1:0]   expQ[$];
    logic [SW-1:0]   expSample;
    logic            clipExpected;
    int              latency;

    voice_mixer #(
        .NUM_VOICES(NV),
        .SAMPLE_W  (SW),
        .GAIN_SHIFT(3),
        .CLIP_HOLD (4800)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .lrck         (lrck),
        .voice_data   (voice_data),
        .voice_active (voice_active),
        .volume       (volume),
        .LDATA        (LDATA),
        .RDATA        (RDATA),
        .sample_strobe(sample_strobe),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .clip         (clip)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference: signed sum of active voices, times volume/128, floored by 8, then clamped
    function automatic logic [SW-1:0] mixModel(input logic [NV*SW-1:0] d, input logic [NV-1:0] a,
                                               input logic [7:0] v);
        longint        sum;
        longint        scaled;
        logic [SW-1:0] s;
        sum = 0;
        for (int i = 0; i < NV; i++) begin
            if (a[i]) begin
                s = d[i*SW +: SW];
                sum += longint'($signed(s));
            end
        end
        scaled = (sum * longint'(v)) >>> 10;
        if (scaled > 32767) return 16'h7FFF;
        if (scaled < -32768) return 16'h8000;
        return scaled[SW-1:0];
    endfunction

    always @(negedge Clk) begin
        if (sample_strobe) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                expSample = expQ.pop_front();
                checkOutput("LDATA", LDATA, expSample);
                checkOutput("RDATA", RDATA, expSample);
            end
        end
    end

    task automatic applyStimulus(input logic [NV*SW-1:0] d, input logic [NV-1:0] a,
                                 input logic [7:0] v, input bit expectOut);
        voice_data   = d;
        voice_active = a;
        volume       = v;
        if (expectOut) expQ.push_back(mixModel(d, a, v));
        lrck = 1'b1;
    endtask

    // mode 0: plain frame, 1: second lrck edge mid-mix, 2: inputs change after the snapshot
    task automatic waitStrobe(input int mode, output int cycles);
        cycles = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clk);
            if (c == 2) lrck = 1'b0;
            if (mode == 1 && c == 3) lrck = 1'b1;
            if (mode == 1 && c == 5) lrck = 1'b0;
            if (mode == 2 && c == 5) voice_data = ~voice_data;
            if (sample_strobe) begin
                cycles = c;
                break;
            end
        end
        if (cycles == 0) checkOutput("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic gap();
        repeat (3) @(negedge Clk);
    endtask

    initial begin
`ifdef VOICE_MIXER_CLIP_HOLD_EN
        clipExpected = 1'b1;
`else
        clipExpected = 1'b0;
`endif
        Reset        = 1'b1;
        lrck         = 1'b0;
        voice_data   = '0;
        voice_active = '0;
        volume       = 8'h80;
        repeat (3) @(negedge Clk);
        checkOutput("reset_LDATA", LDATA, 16'h0000);
        checkOutput("reset_RDATA", RDATA, 16'h0000);
        checkOutput("reset_strobe", sample_strobe, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_overrun", overrun_cnt, 8'd0);
        checkOutput("reset_clip", clip, 1'b0);
        Reset = 1'b0;
        gap();

        applyStimulus({NV{16'h1000}}, 8'hFF, 8'h80, 1'b1);
        waitStrobe(0, latency);
        checkOutput("latency_unity", latency, NV + 4);
        checkOutput("busy_in_out", busy, 1'b1);
        @(negedge Clk);
        checkOutput("strobe_one_cycle", sample_strobe, 1'b0);
        checkOutput("busy_idle", busy, 1'b0);
        gap();

        applyStimulus({{5{16'h7FFF}}, 16'h2000, {2{16'h7FFF}}}, 8'b0000_0100, 8'h80, 1'b1);
        waitStrobe(0, latency);
        gap();

        applyStimulus({NV{16'h7FFF}}, 8'hFF, 8'hFF, 1'b1);
        waitStrobe(0, latency);
        @(negedge Clk);
        checkOutput("clip_after_sat", clip, clipExpected);
        gap();

        applyStimulus({NV{16'h8000}}, 8'hFF, 8'hFF, 1'b1);
        waitStrobe(0, latency);
        gap();

        applyStimulus({{7{16'h7FFF}}, 16'hFFFF}, 8'b0000_0001, 8'h80, 1'b1);
        waitStrobe(0, latency);
        gap();

        applyStimulus({NV{16'h0123}}, 8'hFF, 8'h80, 1'b1);
        waitStrobe(1, latency);
        checkOutput("latency_overrun", latency, NV + 4);
        checkOutput("overrun_cnt", overrun_cnt, 8'd1);
        repeat (20) @(negedge Clk);
        checkOutput("overrun_queue", expQ.size(), 0);

        applyStimulus({16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800},
                      8'hFF, 8'h40, 1'b1);
        waitStrobe(2, latency);
        checkOutput("latency_snapshot", latency, NV + 4);
        gap();

        applyStimulus({NV{16'h0400}}, 8'hFF, 8'h80, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            if (c == 2) lrck = 1'b0;
            if (c == 5) checkOutput("busy_mid_mix", busy, 1'b1);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checkOutput("abort_LDATA", LDATA, 16'h0000);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_overrun", overrun_cnt, 8'd0);
        checkOutput("abort_clip", clip, 1'b0);
        repeat (20) @(negedge Clk);

        applyStimulus({NV{16'h0400}}, 8'b1010_1010, 8'h80, 1'b1);
        waitStrobe(0, latency);
        checkOutput("latency_after_abort", latency, NV + 4);
        gap();

        for (int f = 0; f < 4; f++) begin
            logic [NV*SW-1:0] rnd;
            for (int i = 0; i < NV; i++) rnd[i*SW +: SW] = SW'($urandom);
            applyStimulus(rnd, NV'($urandom), 8'($urandom), 1'b1);
            waitStrobe(0, latency);
            gap();
        end

        repeat (20) @(negedge Clk);
        checkOutput("final_queue", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
